// File: rtl/note_lane_pkg.sv
// note_lane_pkg: LCD character codes, HD44780 command bytes and FSM state types
// shared by the lane engine and its byte writer.
package note_lane_pkg;
    localparam logic [7:0] CH_NOTE  = 8'h4F;
    localparam logic [7:0] CH_BLANK = 8'h20;
    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] ROW0     = 8'h80;
    localparam logic [7:0] ROW1     = 8'hC0;
    typedef enum logic [2:0] {ST_PWR, ST_INIT, ST_IDLE, ST_ROW, ST_DATA} lcd_st_e;
    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_HIGH, W_WAIT} wr_st_e;
    function automatic logic [7:0] init_byte(input logic [1:0] i);
        return i == 2'd0 ? FUNC_SET : i == 2'd1 ? DISP_ON : i == 2'd2 ? ENTRY : CLEAR;
    endfunction
endpackage

// File: rtl/lcd_byte_wr.sv
// lcd_byte_wr: single-byte HD44780 writer; SETUP, E-high, then post-byte wait.
// Ready rises on the last wait cycle so back-to-back bytes have no gap.
module lcd_byte_wr import note_lane_pkg::*; #(
    parameter int T_E   = 50,
    parameter int T_CMD = 2_500,
    parameter int T_CLR = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic       rs_i,
    input  logic       long_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       e_o,
    output logic       rs_o,
    output logic [7:0] data_o
);
    wr_st_e st_q, st_d;
    logic [31:0] cnt_q, cnt_d;
    logic rs_q, rs_d, long_q, long_d, done;
    logic [7:0] data_q, data_d;
    assign done = cnt_q == (st_q == W_HIGH ? 32'(T_E - 1) : long_q ? 32'(T_CLR - 1) : 32'(T_CMD - 1));
    assign ready_o = st_q == W_IDLE || (st_q == W_WAIT && done);
    assign e_o = st_q == W_HIGH;
    assign rs_o = rs_q;
    assign data_o = data_q;
    always_comb begin
        st_d = st_q;
        cnt_d = cnt_q + 32'd1;
        rs_d = rs_q;
        long_d = long_q;
        data_d = data_q;
        if (valid_i && ready_o) begin
            st_d = W_SETUP;
            rs_d = rs_i;
            long_d = long_i;
            data_d = data_i;
        end else if (st_q == W_SETUP) begin
            st_d = W_HIGH;
            cnt_d = '0;
        end else if (st_q == W_HIGH && done) begin
            st_d = W_WAIT;
            cnt_d = '0;
        end else if (st_q == W_WAIT && done) begin
            st_d = W_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= W_IDLE;
            cnt_q <= '0;
            rs_q <= 1'b0;
            long_q <= 1'b0;
            data_q <= '0;
        end else begin
            st_q <= st_d;
            cnt_q <= cnt_d;
            rs_q <= rs_d;
            long_q <= long_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/note_lane_lcd.sv
// note_lane_lcd: scrolling note lanes with hit-window export and an HD44780
// refresh sequencer that redraws the live lanes whenever they change.
module note_lane_lcd import note_lane_pkg::*; #(
    parameter int COLS    = 16,
    parameter int LANES   = 2,
    parameter int PITCH_W = 32,
    parameter int WIN     = 2,
    parameter int T_PWR   = 1_000_000,
    parameter int T_E     = 50,
    parameter int T_CMD   = 2_500,
    parameter int T_CLR   = 100_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_tick,
    input  logic [9:0]                 i_scroll_period,
    input  logic                       i_pause,
    input  logic [LANES-1:0]           i_note,
    input  logic [LANES*PITCH_W-1:0]   i_pitch,
    input  logic [LANES*WIN-1:0]       i_clear,
    output logic [LANES*WIN-1:0]       o_occ,
    output logic [LANES*PITCH_W-1:0]   o_pitch,
    output logic [LANES-1:0]           o_miss,
    output logic                       o_step,
    output logic                       o_lcd_rs,
    output logic                       o_lcd_rw,
    output logic                       o_lcd_e,
    output logic [7:0]                 o_lcd_data,
    output logic                       o_lcd_ready
);
    localparam int IW = $clog2(COLS);
    logic [COLS-1:0] occ_q [LANES], occ_d [LANES];
    logic [PITCH_W-1:0] pit_q [LANES][COLS], pit_d [LANES][COLS];
    logic [PITCH_W-1:0] ppit_q [LANES], ppit_d [LANES];
    logic [LANES-1:0] pend_q, pend_d, miss_q, miss_d;
    logic [9:0] cnt_q, cnt_d, per_m1;
    logic step, step_q, dirty_q, dirty_d, clr_any, frame_start;
    lcd_st_e st_q, st_d;
    logic [31:0] pwr_q, pwr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic row_q, row_d, ready_q, ready_d, valid, rs, long_b, wr_ready;
    logic [7:0] data;
    assign per_m1 = i_scroll_period == 10'd0 ? 10'd0 : i_scroll_period - 10'd1;
    assign step = i_tick && !i_pause && cnt_q >= per_m1;
    assign cnt_d = i_tick && !i_pause ? (step ? 10'd0 : cnt_q + 10'd1) : cnt_q;
    // Clears act on pre-shift contents, so a cleared cell 0 never reports a miss.
    always_comb begin
        clr_any = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            occ_d[l] = occ_q[l];
            for (int k = 0; k < COLS; k++) pit_d[l][k] = pit_q[l][k];
            pend_d[l] = pend_q[l];
            ppit_d[l] = ppit_q[l];
            miss_d[l] = step && occ_q[l][0] && !i_clear[l*WIN];
            for (int k = 0; k < WIN; k++) begin
                clr_any = clr_any | (i_clear[l*WIN+k] & occ_q[l][k]);
                occ_d[l][k] = occ_d[l][k] & ~i_clear[l*WIN+k];
            end
            if (step) begin
                occ_d[l] = {i_note[l] | pend_q[l], occ_d[l][COLS-1:1]};
                for (int k = 0; k < COLS-1; k++) pit_d[l][k] = pit_q[l][k+1];
                pit_d[l][COLS-1] = i_note[l] ? i_pitch[l*PITCH_W +: PITCH_W] : ppit_q[l];
                pend_d[l] = 1'b0;
            end else if (i_note[l]) begin
                pend_d[l] = 1'b1;
                ppit_d[l] = i_pitch[l*PITCH_W +: PITCH_W];
            end
        end
    end
    always_comb begin
        o_occ = '0;
        o_pitch = '0;
        for (int l = 0; l < LANES; l++) begin
            o_pitch[l*PITCH_W +: PITCH_W] = occ_q[l][0] ? pit_q[l][0] : '0;
            for (int k = 0; k < WIN; k++) o_occ[l*WIN+k] = occ_q[l][k];
        end
    end
    assign frame_start = st_q == ST_IDLE && dirty_q;
    assign dirty_d = (dirty_q && !frame_start) || step || clr_any;
    always_comb begin
        st_d = st_q;
        pwr_d = pwr_q;
        idx_d = idx_q;
        row_d = row_q;
        valid = st_q == ST_INIT || st_q == ST_ROW || st_q == ST_DATA;
        rs = st_q == ST_DATA;
        long_b = st_q == ST_INIT && idx_q == IW'(3);
        data = st_q == ST_INIT ? init_byte(idx_q[1:0]) : st_q == ST_ROW ? (row_q ? ROW1 : ROW0) :
               occ_q[row_q][idx_q] ? CH_NOTE : CH_BLANK;
        case (st_q)
            ST_PWR: begin
                pwr_d = pwr_q + 32'd1;
                if (pwr_q == 32'(T_PWR - 1)) st_d = ST_INIT;
            end
            ST_INIT: if (wr_ready) begin
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(3)) st_d = ST_IDLE;
            end
            ST_IDLE: if (dirty_q) begin
                st_d = ST_ROW;
                row_d = 1'b0;
            end
            ST_ROW: if (wr_ready) begin
                st_d = ST_DATA;
                idx_d = '0;
            end
            ST_DATA: if (wr_ready) begin
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(COLS - 1)) begin
                    st_d = row_q == 1'(LANES - 1) ? ST_IDLE : ST_ROW;
                    row_d = 1'b1;
                end
            end
            default: st_d = ST_PWR;
        endcase
    end
    assign ready_d = ready_q | (st_d == ST_IDLE);
    lcd_byte_wr #(.T_E(T_E), .T_CMD(T_CMD), .T_CLR(T_CLR)) u_wr (
        .clk(clk), .rst(rst), .valid_i(valid), .rs_i(rs), .long_i(long_b), .data_i(data),
        .ready_o(wr_ready), .e_o(o_lcd_e), .rs_o(o_lcd_rs), .data_o(o_lcd_data)
    );
    assign o_lcd_rw = 1'b0;
    assign o_lcd_ready = ready_q;
    assign o_miss = miss_q;
    assign o_step = step_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < LANES; l++) begin
                occ_q[l] <= '0;
                ppit_q[l] <= '0;
                for (int k = 0; k < COLS; k++) pit_q[l][k] <= '0;
            end
            pend_q <= '0;
            miss_q <= '0;
            step_q <= 1'b0;
            cnt_q <= '0;
            dirty_q <= 1'b1;
            st_q <= ST_PWR;
            pwr_q <= '0;
            idx_q <= '0;
            row_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            pit_q <= pit_d;
            ppit_q <= ppit_d;
            pend_q <= pend_d;
            miss_q <= miss_d;
            step_q <= step;
            cnt_q <= cnt_d;
            dirty_q <= dirty_d;
            st_q <= st_d;
            pwr_q <= pwr_d;
            idx_q <= idx_d;
            row_q <= row_d;
            ready_q <= ready_d;
        end
    end
endmodule
